systolic_feed_ctrl: RTL and testbench

- Sequencer that drives the operand-feed control pins of the 2x2 systolic array: data_valid, a0_sel, a1_sel, b0_sel, b1_sel, clear, transpose and activation.
- Captures the four array results into holding registers and hands them to downstream logic over a valid/ready interface.
- One start request performs one 2x2 tile multiply, C = A*B or A*B^T.
- Sits between the top-level command logic and the array; operand memories connect directly to the array.

---
 rtl/systolic_feed_ctrl_if.sv | 21 ++
 rtl/systolic_feed_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_systolic_feed_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_feed_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : systolic_feed_ctrl_if
// Brief    : Result hand-off bus (valid/ready plus four captured results).
// Revision : 1.0 - initial release
// ============================================================================
interface systolic_feed_ctrl_if #(
    parameter int ACC_WIDTH = 16
);
    logic                        res_valid;
    logic                        res_ready;
    logic signed [ACC_WIDTH-1:0] r00;
    logic signed [ACC_WIDTH-1:0] r01;
    logic signed [ACC_WIDTH-1:0] r10;
    logic signed [ACC_WIDTH-1:0] r11;

    modport master (output res_valid, r00, r01, r10, r11, input res_ready);
    modport slave  (input res_valid, r00, r01, r10, r11, output res_ready);
endinterface
`default_nettype wire

// File: rtl/systolic_feed_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : systolic_feed_ctrl
// Brief    : Feed sequencer and result capture for a 2x2 systolic array.
//            Optional macro TILE_ACCUM_EN adds accum_in to skip CLEAR.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_feed_ctrl #(
    parameter int ACC_WIDTH    = 16,
    parameter int DRAIN_CYCLES = 2
) (
    input  wire logic                        clk,
    input  wire logic                        rst_n,
    input  wire logic                        start,
    output logic                             start_ready,
    input  wire logic                        transpose_in,
    input  wire logic                        relu_in,
`ifdef TILE_ACCUM_EN
    input  wire logic                        accum_in,
`endif
    output logic                             busy,
    output logic                             data_valid,
    output logic [1:0]                       a0_sel,
    output logic [1:0]                       a1_sel,
    output logic [1:0]                       b0_sel,
    output logic [1:0]                       b1_sel,
    output logic                             clear,
    output logic                             transpose,
    output logic                             activation,
    input  wire logic signed [ACC_WIDTH-1:0] c00_in,
    input  wire logic signed [ACC_WIDTH-1:0] c01_in,
    input  wire logic signed [ACC_WIDTH-1:0] c10_in,
    input  wire logic signed [ACC_WIDTH-1:0] c11_in,
    systolic_feed_ctrl_if.master             res
);

    localparam int         CNT_W      = $clog2(DRAIN_CYCLES);
    localparam logic [1:0] SEL_FIRST  = 2'd0;
    localparam logic [1:0] SEL_SECOND = 2'd1;
    localparam logic [1:0] SEL_ZERO   = 2'd2;

    generate
        if (DRAIN_CYCLES < 2) begin : g_bad_drain
            $error("DRAIN_CYCLES must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_FEED0   = 3'd2,
        S_FEED1   = 3'd3,
        S_FEED2   = 3'd4,
        S_DRAIN   = 3'd5,
        S_CAPTURE = 3'd6,
        S_HOLD    = 3'd7
    } state_t;

    typedef struct packed {
        logic       dv;
        logic       clr;
        logic [1:0] a0;
        logic [1:0] a1;
        logic [1:0] b0;
        logic [1:0] b1;
    } ctrl_t;

    // Array pin values that belong to a state; registered on entry so the
    // pins change exactly when the state does.
    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c.dv  = 1'b0;
        c.clr = 1'b0;
        c.a0  = SEL_ZERO;
        c.a1  = SEL_ZERO;
        c.b0  = SEL_ZERO;
        c.b1  = SEL_ZERO;
        case (s)
            S_CLEAR: c.clr = 1'b1;
            S_FEED0: begin
                c.dv = 1'b1; c.a0 = SEL_FIRST;  c.b0 = SEL_FIRST;
            end
            S_FEED1: begin
                c.dv = 1'b1; c.a0 = SEL_SECOND; c.a1 = SEL_FIRST;
                c.b0 = SEL_SECOND; c.b1 = SEL_FIRST;
            end
            S_FEED2: begin
                c.dv = 1'b1; c.a1 = SEL_SECOND; c.b1 = SEL_SECOND;
            end
            default: ;
        endcase
        return c;
    endfunction

    state_t                      r_state;
    ctrl_t                       r_ctrl;
    logic [CNT_W-1:0]            r_drain;
    logic                        r_busy;
    logic                        r_start_ready;
    logic                        r_transpose;
    logic                        r_activation;
    logic                        r_res_valid;
    logic signed [ACC_WIDTH-1:0] r_r00, r_r01, r_r10, r_r11;

    logic   w_accept;
    state_t w_first;

    assign w_accept = start & r_start_ready;
`ifdef TILE_ACCUM_EN
    assign w_first  = accum_in ? S_FEED0 : S_CLEAR;
`else
    assign w_first  = S_CLEAR;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_ctrl        <= ctrl_of(S_IDLE);
            r_drain       <= '0;
            r_busy        <= 1'b0;
            r_start_ready <= 1'b1;
            r_transpose   <= 1'b0;
            r_activation  <= 1'b0;
            r_res_valid   <= 1'b0;
            r_r00         <= '0;
            r_r01         <= '0;
            r_r10         <= '0;
            r_r11         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state       <= w_first;
                        r_ctrl        <= ctrl_of(w_first);
                        r_busy        <= 1'b1;
                        r_start_ready <= 1'b0;
                        r_transpose   <= transpose_in;
                        r_activation  <= relu_in;
                    end
                end
                S_CLEAR: begin
                    r_state <= S_FEED0;
                    r_ctrl  <= ctrl_of(S_FEED0);
                end
                S_FEED0: begin
                    r_state <= S_FEED1;
                    r_ctrl  <= ctrl_of(S_FEED1);
                end
                S_FEED1: begin
                    r_state <= S_FEED2;
                    r_ctrl  <= ctrl_of(S_FEED2);
                end
                S_FEED2: begin
                    r_state <= S_DRAIN;
                    r_ctrl  <= ctrl_of(S_DRAIN);
                    r_drain <= CNT_W'(DRAIN_CYCLES - 1);
                end
                S_DRAIN: begin
                    if (r_drain == '0) begin
                        r_state <= S_CAPTURE;
                        r_ctrl  <= ctrl_of(S_CAPTURE);
                    end else begin
                        r_drain <= r_drain - CNT_W'(1);
                    end
                end
                // activation is still driven here: the array ReLU is
                // combinational, so the captured values depend on it.
                S_CAPTURE: begin
                    r_state     <= S_HOLD;
                    r_ctrl      <= ctrl_of(S_HOLD);
                    r_res_valid <= 1'b1;
                    r_r00       <= c00_in;
                    r_r01       <= c01_in;
                    r_r10       <= c10_in;
                    r_r11       <= c11_in;
                end
                S_HOLD: begin
                    if (res.res_ready) begin
                        r_state       <= S_IDLE;
                        r_ctrl        <= ctrl_of(S_IDLE);
                        r_res_valid   <= 1'b0;
                        r_busy        <= 1'b0;
                        r_start_ready <= 1'b1;
                        r_transpose   <= 1'b0;
                        r_activation  <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_ctrl        <= ctrl_of(S_IDLE);
                    r_busy        <= 1'b0;
                    r_start_ready <= 1'b1;
                    r_res_valid   <= 1'b0;
                end
            endcase
        end
    end

    assign start_ready   = r_start_ready;
    assign busy          = r_busy;
    assign data_valid    = r_ctrl.dv;
    assign clear         = r_ctrl.clr;
    assign a0_sel        = r_ctrl.a0;
    assign a1_sel        = r_ctrl.a1;
    assign b0_sel        = r_ctrl.b0;
    assign b1_sel        = r_ctrl.b1;
    assign transpose     = r_transpose;
    assign activation    = r_activation;
    assign res.res_valid = r_res_valid;
    assign res.r00       = r_r00;
    assign res.r01       = r_r01;
    assign res.r10       = r_r10;
    assign res.r11       = r_r11;

endmodule
`default_nettype wire

// File: tb/tb_systolic_feed_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_systolic_feed_ctrl
// Brief    : Scoreboard bench with a behavioural 2x2 systolic array attached.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_feed_ctrl;

    localparam int AW = 16;
    localparam logic [63:0] EXP_NORMAL = {16'd19, 16'd22, 16'd43, 16'd50};
    localparam logic [63:0] EXP_TRANS  = {16'd17, 16'd23, 16'd39, 16'd53};
    localparam logic [63:0] EXP_RELU   = {16'd0, 16'd0, 16'd0, 16'd1};
    localparam logic [63:0] EXP_NORELU = {16'hFFFF, 16'd0, 16'd0, 16'd1};
    localparam logic [14:0] RST_CTRL   = {1'b1, 6'b000000, 8'hAA};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, transpose_in, relu_in;
    logic start_ready, busy, data_valid, clear, transpose, activation;
    logic [1:0] a0_sel, a1_sel, b0_sel, b1_sel;
    logic signed [AW-1:0] c00, c01, c10, c11;
`ifdef TILE_ACCUM_EN
    logic accum_in;
`endif

    systolic_feed_ctrl_if #(.ACC_WIDTH(AW)) res_if ();

    systolic_feed_ctrl #(.ACC_WIDTH(AW), .DRAIN_CYCLES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .start_ready  (start_ready),
        .transpose_in (transpose_in),
        .relu_in      (relu_in),
`ifdef TILE_ACCUM_EN
        .accum_in     (accum_in),
`endif
        .busy         (busy),
        .data_valid   (data_valid),
        .a0_sel       (a0_sel),
        .a1_sel       (a1_sel),
        .b0_sel       (b0_sel),
        .b1_sel       (b1_sel),
        .clear        (clear),
        .transpose    (transpose),
        .activation   (activation),
        .c00_in       (c00),
        .c01_in       (c01),
        .c10_in       (c10),
        .c11_in       (c11),
        .res          (res_if)
    );

    // Behavioural array: row operands move right, column operands move down,
    // one register stage per PE hop.
    logic signed [AW-1:0] mA [2][2];
    logic signed [AW-1:0] mB [2][2];
    logic signed [AW-1:0] acc [2][2];
    logic signed [AW-1:0] a0v, a1v, b0v, b1v, a0d, a1d, b0d, b1d;

    always_comb begin
        a0v = (data_valid && a0_sel != 2'd2) ? mA[0][a0_sel[0]] : '0;
        a1v = (data_valid && a1_sel != 2'd2) ? mA[1][a1_sel[0]] : '0;
        b0v = (data_valid && b0_sel != 2'd2) ?
              (transpose ? mB[0][b0_sel[0]] : mB[b0_sel[0]][0]) : '0;
        b1v = (data_valid && b1_sel != 2'd2) ?
              (transpose ? mB[1][b1_sel[0]] : mB[b1_sel[0]][1]) : '0;
    end

    always @(posedge clk) begin
        a0d <= a0v; a1d <= a1v; b0d <= b0v; b1d <= b1v;
        if (!rst_n || clear) begin
            acc[0][0] <= '0; acc[0][1] <= '0; acc[1][0] <= '0; acc[1][1] <= '0;
        end else begin
            acc[0][0] <= acc[0][0] + a0v * b0v;
            acc[0][1] <= acc[0][1] + a0d * b1v;
            acc[1][0] <= acc[1][0] + a1v * b0d;
            acc[1][1] <= acc[1][1] + a1d * b1d;
        end
    end

    always_comb begin
        c00 = (activation && acc[0][0][AW-1]) ? '0 : acc[0][0];
        c01 = (activation && acc[0][1][AW-1]) ? '0 : acc[0][1];
        c10 = (activation && acc[1][0][AW-1]) ? '0 : acc[1][0];
        c11 = (activation && acc[1][1][AW-1]) ? '0 : acc[1][1];
    end

    typedef struct {
        logic [63:0] v;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_hs     = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        $display("FAIL %s", nm);
    endtask

    task automatic push_exp(input logic [63:0] v, input string nm);
        exp_t e;
        e.v  = v;
        e.nm = nm;
        exp_q.push_back(e);
    endtask

    function automatic logic [63:0] res_vec();
        return {res_if.r00, res_if.r01, res_if.r10, res_if.r11};
    endfunction

    function automatic logic [14:0] ctrl_vec();
        return {start_ready, busy, data_valid, clear, transpose, activation,
                res_if.res_valid, a0_sel, a1_sel, b0_sel, b1_sel};
    endfunction

    function automatic logic [12:0] seq_vec();
        return {start_ready, busy, clear, data_valid, res_if.res_valid,
                a0_sel, a1_sel, b0_sel, b1_sel};
    endfunction

    function automatic logic [12:0] seq_exp(input int k);
        logic [7:0] s;
        case (k)
            2:       s = 8'b00_10_00_10;
            3:       s = 8'b01_00_01_00;
            4:       s = 8'b10_01_10_01;
            default: s = 8'hAA;
        endcase
        return {(k == 0 || k >= 9), (k >= 1 && k <= 8), (k == 1),
                (k >= 2 && k <= 4), (k == 8), s};
    endfunction

    // Scoreboard monitor: one pop per result handshake.
    always @(negedge clk) begin
        if (rst_n && res_if.res_valid && res_if.res_ready) begin
            n_hs++;
            if (exp_q.size() == 0) begin
                fail_now("unexpected result handshake");
            end else begin
                mon_e = exp_q.pop_front();
                check(mon_e.nm, res_vec(), mon_e.v);
            end
        end
    end

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!res_if.res_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!res_if.res_valid) fail_now({nm, " timeout waiting for res_valid"});
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((busy || res_if.res_valid) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) fail_now({nm, " timeout waiting for idle"});
    endtask

    task automatic run_tile(input logic tr, input logic rl, input logic [63:0] expv,
                            input string nm);
        @(posedge clk); #1;
        push_exp(expv, nm);
        start = 1'b1; transpose_in = tr; relu_in = rl;
        @(posedge clk); #1;
        start = 1'b0; transpose_in = 1'b0; relu_in = 1'b0;
        wait_valid(nm);
        check({nm, " latched mode"}, {transpose, activation}, {tr, rl});
        wait_idle(nm);
        check({nm, " mode cleared"}, {transpose, activation}, 2'b00);
    endtask

    task automatic load_normal();
        mA[0][0] = 1; mA[0][1] = 2; mA[1][0] = 3; mA[1][1] = 4;
        mB[0][0] = 5; mB[0][1] = 6; mB[1][0] = 7; mB[1][1] = 8;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        rst_n = 1'b0; start = 1'b0; transpose_in = 1'b0; relu_in = 1'b0;
        res_if.res_ready = 1'b1;
`ifdef TILE_ACCUM_EN
        accum_in = 1'b0;
`endif
        load_normal();
        repeat (2) @(negedge clk);
        check("reset controls", 64'(ctrl_vec()), 64'(RST_CTRL));
        check("reset results", res_vec(), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Cycle-exact sequence from acceptance at T through T+10.
        @(posedge clk); #1;
        push_exp(EXP_NORMAL, "normal multiply");
        start = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            check($sformatf("sequence T+%0d", k), 64'(seq_vec()), 64'(seq_exp(k)));
            @(posedge clk); #1;
            start = 1'b0;
        end

        run_tile(1'b1, 1'b0, EXP_TRANS, "transpose multiply");

        mA[0][0] = -1; mA[0][1] = 0; mA[1][0] = 0; mA[1][1] = 1;
        mB[0][0] = 1;  mB[0][1] = 0; mB[1][0] = 0; mB[1][1] = 1;
        run_tile(1'b0, 1'b1, EXP_RELU, "relu on");
        run_tile(1'b0, 1'b0, EXP_NORELU, "relu off");

        // Backpressure: result held for 5 cycles while start is pulsed.
        load_normal();
        res_if.res_ready = 1'b0;
        @(posedge clk); #1;
        push_exp(EXP_NORMAL, "backpressure result");
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid("backpressure");
        hs0 = n_hs;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp results stable %0d", i), res_vec(), EXP_NORMAL);
            check($sformatf("bp valid/ready %0d", i),
                  {62'd0, res_if.res_valid, start_ready}, 64'b10);
            @(posedge clk); #1;
            start = (i % 2 == 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        start = 1'b0;
        res_if.res_ready = 1'b1;
        @(negedge clk);
        wait_idle("backpressure");
        check("bp single handshake", 64'(n_hs - hs0), 64'd1);
        repeat (3) @(negedge clk);
        check("bp start not queued", {63'd0, busy}, 64'd0);

        // Reset asserted during FEED1.
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("in feed1 before reset", {55'd0, data_valid, a0_sel, a1_sel, b0_sel, b1_sel},
              {55'd0, 1'b1, 8'b01_00_01_00});
        rst_n = 1'b0;
        #1;
        check("mid-op reset controls", 64'(ctrl_vec()), 64'(RST_CTRL));
        check("mid-op reset results", res_vec(), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_tile(1'b0, 1'b0, EXP_NORMAL, "after reset multiply");

        repeat (2) @(negedge clk);
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
